eim_da_ctrl: RTL and testbench
==============================

# eim_da_ctrl

Synchronous EIM slave controller that sits directly upstream of the DA-port IO buffer (`eim_da_phy`). It synchronizes the i.MX EIM strobes into `sys_clk` and latches the 16-bit address from the multiplexed DA bus. It converts two 16-bit data beats into one 32-bit system-bus write or read, and drives the buffer's drive-data and tristate controls plus `eim_wait_n` for read flow control.

## Interface
- `BUS_WIDTH`, 16: DA bus width. The system data word is 2×BUS_WIDTH.
- `ADDR_WIDTH`, 16: system address width. Must be ≤ BUS_WIDTH; the address is taken from `phy_ro[ADDR_WIDTH-1:0]`.
- `TIMEOUT`, 255: maximum cycles to wait for `sys_rvalid` before a read is completed with the error word.
- `sys_clk` in 1: single clock.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `eim_cs_n` in 1: chip select, asynchronous to `sys_clk`.
- `eim_lba_n` in 1: address-latch strobe, asynchronous.
- `eim_wr_n` in 1: write-beat strobe, asynchronous.
- `eim_oe_n` in 1: read-beat strobe, asynchronous.
- `eim_wait_n` out 1: low means the host must stall the current read beat.
- `phy_ro` in BUS_WIDTH: value read from the DA pins.
- `phy_di` out BUS_WIDTH: value to drive onto the DA pins.
- `phy_t` out 1: tristate control; 1 means the pin drivers are off.
- `sys_addr` out ADDR_WIDTH: latched transaction address.
- `sys_wr` out 1: one-cycle write request.
- `sys_wdata` out 2×BUS_WIDTH: write word, valid while `sys_wr` is high.
- `sys_rd` out 1: one-cycle read request.
- `sys_rdata` in 2×BUS_WIDTH: read word, sampled when `sys_rvalid` is high.
- `sys_rvalid` in 1: read data valid. A pulse seen while no read is pending is ignored.

## Operation
- **Synchronizers.** Each of the four strobes passes through a 2-FF synchronizer. Suffix `_s` denotes the synchronized value. An edge means a change between consecutive `_s` samples. DA data is sampled directly, because it is stable for longer than the synchronizer latency.
- **States:** IDLE, ADDR, WR, RD_REQ, RD_WAIT, RD_DRIVE.
- **IDLE.**
  - Enter ADDR when `cs_s`=0 and `lba_s`=0.
  - On entry to ADDR: `sys_addr` ← `phy_ro[ADDR_WIDTH-1:0]`, beat counter ← 0.
- **ADDR.** Wait for `lba_s`=1.
  - A later falling `wr_s` edge goes to WR.
  - A later falling `oe_s` edge goes to RD_REQ.
- **WR (write beats).**
  - Beat 0 falling `wr_s` edge: capture `sys_wdata[BUS_WIDTH-1:0]`.
  - Beat 1 falling `wr_s` edge: capture the upper half.
  - The beat counter advances on each rising `wr_s` edge.
  - On the rising edge that ends beat 1: pulse `sys_wr` for one cycle, then go to IDLE.
- **RD_REQ.** Pulse `sys_rd` for one cycle, drive `eim_wait_n`=0, go to RD_WAIT. The timeout counter clears.
- **RD_WAIT.**
  - On `sys_rvalid`: latch `sys_rdata`, go to RD_DRIVE.
  - If the counter reaches TIMEOUT first: latch `EIM_ERR_WORD` (32'hDEAD_BEEF), go to RD_DRIVE.
  - `eim_wait_n` returns to 1 on entry to RD_DRIVE.
- **RD_DRIVE.**
  - While `oe_s`=0: `phy_t`=0, and `phy_di` = low half for beat 0, high half for beat 1.
  - A rising `oe_s` edge sets `phy_t`=1 and advances the beat counter.
  - After beat 1 ends, go to IDLE.
- **Abort.** `cs_s`=1 in any state other than IDLE forces IDLE next cycle.
  - Outputs: `phy_t`=1, `eim_wait_n`=1.
  - An incomplete write issues no `sys_wr`.
  - A `sys_rd` already issued is not retracted; its late `sys_rvalid` is ignored.
- **Both strobes low.** If `wr_s` and `oe_s` fall in the same cycle while in ADDR, write takes priority.
- **Reset values:** state IDLE, `phy_t`=1, `phy_di`=0, `eim_wait_n`=1, `sys_wr`=0, `sys_rd`=0, `sys_addr`=0, `sys_wdata`=0, beat and timeout counters 0. Reset mid-transaction behaves identically to an abort.

## Timing
- Strobe pin to `_s`: 2 cycles. All outputs are registered.
- Write: `sys_wr` is high in cycle N+1, where N is the cycle the beat-1 rising `wr_s` edge is detected. `sys_wdata` and `sys_addr` are stable from then until the next transaction starts.
- Read: `sys_rd` is high in cycle N+1 after the first falling `oe_s` edge. `eim_wait_n`=0 from that same cycle.
- Read release: `eim_wait_n`=1 and `phy_t`=0 in the cycle after `sys_rvalid` is sampled. Minimum read latency from `sys_rd` is therefore 2 cycles.
- Timeout: the error word is presented TIMEOUT+1 cycles after `sys_rd`.
- Turnaround: `phy_t` rises in the cycle after a rising `oe_s` edge, so DA is never driven while `oe_s`=1 for more than 1 cycle.

## Structure
- Shared package `eim_pkg` holds:
  - the state enum,
  - `EIM_ERR_WORD`,
  - the default `BUS_WIDTH`.
- Sub-module `eim_sync`: a single-bit 2-FF synchronizer with a synchronous active-low reset value parameter. It is instantiated four times, with reset values 1,1,1,1.

## Test plan
- **Write.** Address 0x0042, beats 0xBEEF then 0xDEAD. Expect exactly one `sys_wr` with `sys_addr`=0x0042 and `sys_wdata`=0xDEADBEEF.
- **Read.** Address 0x0010; `sys_rvalid` 3 cycles after `sys_rd` with 0x12345678. Expect `eim_wait_n` low for 4 cycles, beat 0 driving 0x5678 and beat 1 driving 0x1234, `phy_t`=0 only while `oe` is low.
- **Read timeout** (TIMEOUT=8). No `sys_rvalid`. Expect `eim_wait_n` released after 9 cycles and beats 0xBEEF then 0xDEAD. A late `sys_rvalid` is ignored.
- **Write abort.** Raise `cs_n` after beat 0. Expect no `sys_wr` and IDLE; the next full write then completes normally.
- **Reset mid-read.** Assert `sys_rst_n` during RD_DRIVE. Expect `phy_t`=1, `eim_wait_n`=1 and all outputs at their reset values on the next cycle.
- **Back-to-back.** Write then read with one idle cycle of `cs_n` high between them. Expect both transactions to complete with correct address and data.

Source files
------------

// File: rtl/eim_pkg.sv
// Shared types and constants for the EIM DA-port controller.
package eim_pkg;

  localparam int unsigned EIM_BUS_WIDTH = 16;
  localparam logic [31:0] EIM_ERR_WORD  = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_DRIVE
  } eim_state_e;

endpackage

// File: rtl/eim_sync.sv
// Single-bit two-flop synchronizer with a configurable reset value.
module eim_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/eim_da_ctrl.sv
// EIM slave: syncs host strobes, latches the muxed address and turns two DA beats into one 32-bit access.
module eim_da_ctrl
  import eim_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = EIM_BUS_WIDTH,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   eim_cs_n,
  input  logic                   eim_lba_n,
  input  logic                   eim_wr_n,
  input  logic                   eim_oe_n,
  output logic                   eim_wait_n,
  input  logic [BUS_WIDTH-1:0]   phy_ro,
  output logic [BUS_WIDTH-1:0]   phy_di,
  output logic                   phy_t,
  output logic [ADDR_WIDTH-1:0]  sys_addr,
  output logic                   sys_wr,
  output logic [2*BUS_WIDTH-1:0] sys_wdata,
  output logic                   sys_rd,
  input  logic [2*BUS_WIDTH-1:0] sys_rdata,
  input  logic                   sys_rvalid
);

  localparam int unsigned DW = 2 * BUS_WIDTH;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] ERR_WORD = DW'(EIM_ERR_WORD);

  logic cs_s, lba_s, wr_s, oe_s;

  eim_sync #(.RST_VAL(1'b1)) u_sync_cs  (.clk(sys_clk), .rst_n(sys_rst_n), .d(eim_cs_n),  .q(cs_s));
  eim_sync #(.RST_VAL(1'b1)) u_sync_lba (.clk(sys_clk), .rst_n(sys_rst_n), .d(eim_lba_n), .q(lba_s));
  eim_sync #(.RST_VAL(1'b1)) u_sync_wr  (.clk(sys_clk), .rst_n(sys_rst_n), .d(eim_wr_n),  .q(wr_s));
  eim_sync #(.RST_VAL(1'b1)) u_sync_oe  (.clk(sys_clk), .rst_n(sys_rst_n), .d(eim_oe_n),  .q(oe_s));

  eim_state_e            state_q, state_d;
  logic                  wr_p_q, oe_p_q;
  logic                  beat_q, beat_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [BUS_WIDTH-1:0]  phy_di_q, phy_di_d;
  logic                  phy_t_q, phy_t_d;
  logic                  wait_n_q, wait_n_d;
  logic                  sys_wr_q, sys_wr_d;
  logic                  sys_rd_q, sys_rd_d;

  logic          wr_fall, wr_rise, oe_fall, oe_rise;
  logic [DW-1:0] rword;

  assign wr_fall = wr_p_q & ~wr_s;
  assign wr_rise = ~wr_p_q & wr_s;
  assign oe_fall = oe_p_q & ~oe_s;
  assign oe_rise = ~oe_p_q & oe_s;
  assign rword   = sys_rvalid ? sys_rdata : ERR_WORD;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    tmo_d    = tmo_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    phy_di_d = phy_di_q;
    phy_t_d  = phy_t_q;
    wait_n_d = wait_n_q;
    sys_wr_d = 1'b0;
    sys_rd_d = 1'b0;

    if (state_q != ST_IDLE && cs_s) begin
      state_d  = ST_IDLE;
      phy_t_d  = 1'b1;
      wait_n_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          phy_t_d  = 1'b1;
          wait_n_d = 1'b1;
          if (!cs_s && !lba_s) begin
            state_d = ST_ADDR;
            addr_d  = phy_ro[ADDR_WIDTH-1:0];
            beat_d  = 1'b0;
          end
        end
        ST_ADDR: begin
          // The edge that leaves ADDR is itself beat 0, so write data is captured here.
          if (lba_s) begin
            if (wr_fall) begin
              state_d                  = ST_WR;
              wdata_d[BUS_WIDTH-1:0]   = phy_ro;
            end else if (oe_fall) begin
              state_d  = ST_RD_REQ;
              sys_rd_d = 1'b1;
              wait_n_d = 1'b0;
            end
          end
        end
        ST_WR: begin
          if (wr_fall && beat_q)
            wdata_d[DW-1:BUS_WIDTH] = phy_ro;
          if (wr_rise) begin
            beat_d = beat_q + 1'b1;
            if (beat_q) begin
              sys_wr_d = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
        ST_RD_REQ: begin
          wait_n_d = 1'b0;
          tmo_d    = '0;
          state_d  = ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // Data and timeout share one exit path; rword picks the error word when rvalid is absent.
          if (sys_rvalid || tmo_q == TMO_LAST) begin
            rdata_d  = rword;
            phy_di_d = rword[BUS_WIDTH-1:0];
            phy_t_d  = oe_s;
            wait_n_d = 1'b1;
            state_d  = ST_RD_DRIVE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_RD_DRIVE: begin
          phy_t_d = oe_s;
          if (!oe_s)
            phy_di_d = beat_q ? rdata_q[DW-1:BUS_WIDTH] : rdata_q[BUS_WIDTH-1:0];
          if (oe_rise) begin
            beat_d = beat_q + 1'b1;
            if (beat_q)
              state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      wr_p_q   <= 1'b1;
      oe_p_q   <= 1'b1;
      beat_q   <= 1'b0;
      tmo_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      phy_di_q <= '0;
      phy_t_q  <= 1'b1;
      wait_n_q <= 1'b1;
      sys_wr_q <= 1'b0;
      sys_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_p_q   <= wr_s;
      oe_p_q   <= oe_s;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      phy_di_q <= phy_di_d;
      phy_t_q  <= phy_t_d;
      wait_n_q <= wait_n_d;
      sys_wr_q <= sys_wr_d;
      sys_rd_q <= sys_rd_d;
    end
  end

  assign eim_wait_n = wait_n_q;
  assign phy_di     = phy_di_q;
  assign phy_t      = phy_t_q;
  assign sys_addr   = addr_q;
  assign sys_wr     = sys_wr_q;
  assign sys_wdata  = wdata_q;
  assign sys_rd     = sys_rd_q;

endmodule

// File: tb/tb_eim_da_ctrl.sv
// Self-checking bench for eim_da_ctrl: host bus model, rvalid responder and transaction-level expectations.
module tb_eim_da_ctrl;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        eim_cs_n = 1'b1;
  logic        eim_lba_n = 1'b1;
  logic        eim_wr_n = 1'b1;
  logic        eim_oe_n = 1'b1;
  logic        eim_wait_n;
  logic [15:0] phy_ro = '0;
  logic [15:0] phy_di;
  logic        phy_t;
  logic [15:0] sys_addr;
  logic        sys_wr;
  logic [31:0] sys_wdata;
  logic        sys_rd;
  logic [31:0] sys_rdata = '0;
  logic        sys_rvalid = 1'b0;

  always #5 sys_clk = ~sys_clk;

  eim_da_ctrl #(
    .BUS_WIDTH (16),
    .ADDR_WIDTH(16),
    .TIMEOUT   (TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .eim_cs_n  (eim_cs_n),
    .eim_lba_n (eim_lba_n),
    .eim_wr_n  (eim_wr_n),
    .eim_oe_n  (eim_oe_n),
    .eim_wait_n(eim_wait_n),
    .phy_ro    (phy_ro),
    .phy_di    (phy_di),
    .phy_t     (phy_t),
    .sys_addr  (sys_addr),
    .sys_wr    (sys_wr),
    .sys_wdata (sys_wdata),
    .sys_rd    (sys_rd),
    .sys_rdata (sys_rdata),
    .sys_rvalid(sys_rvalid)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [47:0] wr_q[$];
  logic [15:0] rd_q[$];
  int          wait_low = 0;
  int          oe_hi_run = 0;
  int          drive_bad = 0;
  int          resp_delay = 0;
  logic [31:0] resp_data = '0;

  // Observer: logs system-side requests and watches for DA being driven outside a read beat.
  initial forever begin
    @(posedge sys_clk); #1;
    if (sys_wr === 1'b1) wr_q.push_back({sys_addr, sys_wdata});
    if (sys_rd === 1'b1) rd_q.push_back(sys_addr);
    if (eim_wait_n === 1'b0) wait_low++;
    if (eim_oe_n) oe_hi_run++; else oe_hi_run = 0;
    if (phy_t === 1'b0 && oe_hi_run > 3) drive_bad++;
  end

  // System-side responder: answers each sys_rd after resp_delay cycles (0 = never).
  initial forever begin
    @(posedge sys_clk); #1;
    if (sys_rd === 1'b1 && resp_delay != 0) begin
      repeat (resp_delay) @(posedge sys_clk);
      #1;
      sys_rvalid = 1'b1;
      sys_rdata  = resp_data;
      @(posedge sys_clk); #1;
      sys_rvalid = 1'b0;
      sys_rdata  = 32'($urandom);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic start_cycle(input logic [15:0] a);
    eim_cs_n  = 1'b0;
    eim_lba_n = 1'b0;
    phy_ro    = a;
    idle(4);
    eim_lba_n = 1'b1;
    idle(3);
  endtask

  task automatic wr_beat(input logic [15:0] d);
    phy_ro = d;
    idle(1);
    eim_wr_n = 1'b0;
    idle(4);
    eim_wr_n = 1'b1;
    idle(3);
  endtask

  task automatic end_cycle(input int gap);
    eim_cs_n = 1'b1;
    phy_ro   = 16'($urandom);
    idle(gap);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    idle(3);
    n_checks++;
    if ({phy_t, eim_wait_n, sys_wr, sys_rd} !== 4'b1100)
      $display("FAIL reset_ctl: got t/wait/wr/rd=%b expected 1100", {phy_t, eim_wait_n, sys_wr, sys_rd});
    else n_pass++;
    n_checks++;
    if ({phy_di, sys_addr, sys_wdata} !== 64'h0)
      $display("FAIL reset_data: got di=%h addr=%h wdata=%h expected all zero", phy_di, sys_addr, sys_wdata);
    else n_pass++;
    sys_rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_write(input logic [15:0] a, input logic [31:0] d, input int gap);
    wr_q.delete();
    start_cycle(a);
    wr_beat(d[15:0]);
    wr_beat(d[31:16]);
    end_cycle(gap);
    n_checks++;
    if (wr_q.size() != 1)
      $display("FAIL write_count: got %0d sys_wr pulses expected 1 (addr %h)", wr_q.size(), a);
    else n_pass++;
    if (wr_q.size() >= 1) begin
      n_checks++;
      if (wr_q[0] !== {a, d})
        $display("FAIL write_word: got addr/data %h expected %h", wr_q[0], {a, d});
      else n_pass++;
    end
  endtask

  task automatic test_read(input logic [15:0] a, input logic [31:0] w, input int d, input int gap);
    logic [31:0] exp_w;
    int          exp_low;
    int          k;
    exp_w   = (d != 0 && d <= int'(TMO)) ? w : ERR;
    exp_low = (d != 0 && d <= int'(TMO)) ? d + 1 : int'(TMO) + 1;
    resp_delay = d;
    resp_data  = w;
    rd_q.delete();
    start_cycle(a);
    wait_low = 0;
    eim_oe_n = 1'b0;
    idle(3);
    for (k = 0; k < 60 && eim_wait_n !== 1'b1; k++) idle(1);
    n_checks++;
    if (k >= 60) $display("FAIL read_release: eim_wait_n still %b after 60 cycles expected 1", eim_wait_n);
    else n_pass++;
    idle(1);
    n_checks++;
    if ({phy_t, phy_di} !== {1'b0, exp_w[15:0]})
      $display("FAIL read_beat0: got t=%b di=%h expected t=0 di=%h", phy_t, phy_di, exp_w[15:0]);
    else n_pass++;
    eim_oe_n = 1'b1;
    idle(4);
    n_checks++;
    if (phy_t !== 1'b1) $display("FAIL read_turn0: got phy_t=%b expected 1", phy_t);
    else n_pass++;
    eim_oe_n = 1'b0;
    idle(4);
    n_checks++;
    if ({phy_t, phy_di} !== {1'b0, exp_w[31:16]})
      $display("FAIL read_beat1: got t=%b di=%h expected t=0 di=%h", phy_t, phy_di, exp_w[31:16]);
    else n_pass++;
    eim_oe_n = 1'b1;
    idle(4);
    n_checks++;
    if ({phy_t, eim_wait_n} !== 2'b11)
      $display("FAIL read_end: got t/wait=%b expected 11", {phy_t, eim_wait_n});
    else n_pass++;
    n_checks++;
    if (wait_low != exp_low)
      $display("FAIL read_wait_len: got %0d low cycles expected %0d (delay %0d)", wait_low, exp_low, d);
    else n_pass++;
    n_checks++;
    if (rd_q.size() != 1 || rd_q[0] !== a)
      $display("FAIL read_req: got %0d sys_rd pulses addr %h expected 1 pulse addr %h",
               rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx, a);
    else n_pass++;
    end_cycle(gap);
  endtask

  task automatic test_write_abort(input logic [15:0] a, input logic [31:0] d);
    wr_q.delete();
    start_cycle(a);
    wr_beat(d[15:0]);
    eim_cs_n = 1'b1;
    idle(6);
    n_checks++;
    if (wr_q.size() != 0) $display("FAIL abort_nowr: got %0d sys_wr pulses expected 0", wr_q.size());
    else n_pass++;
    n_checks++;
    if ({phy_t, eim_wait_n} !== 2'b11) $display("FAIL abort_idle: got t/wait=%b expected 11", {phy_t, eim_wait_n});
    else n_pass++;
    test_write(a ^ 16'h0101, ~d, 3);
  endtask

  task automatic test_reset_mid_read(input logic [15:0] a, input logic [31:0] w);
    int k;
    resp_delay = 2;
    resp_data  = w;
    start_cycle(a);
    eim_oe_n = 1'b0;
    idle(3);
    for (k = 0; k < 60 && eim_wait_n !== 1'b1; k++) idle(1);
    idle(1);
    n_checks++;
    if ({phy_t, phy_di} !== {1'b0, w[15:0]})
      $display("FAIL rstrd_drive: got t=%b di=%h expected t=0 di=%h", phy_t, phy_di, w[15:0]);
    else n_pass++;
    sys_rst_n = 1'b0;
    idle(1);
    n_checks++;
    if ({phy_t, eim_wait_n, sys_wr, sys_rd} !== 4'b1100)
      $display("FAIL rstrd_ctl: got t/wait/wr/rd=%b expected 1100", {phy_t, eim_wait_n, sys_wr, sys_rd});
    else n_pass++;
    n_checks++;
    if ({phy_di, sys_addr, sys_wdata} !== 64'h0)
      $display("FAIL rstrd_data: got di=%h addr=%h wdata=%h expected all zero", phy_di, sys_addr, sys_wdata);
    else n_pass++;
    eim_oe_n = 1'b1;
    eim_cs_n = 1'b1;
    sys_rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_back_to_back(input logic [15:0] a1, input logic [31:0] d1,
                                   input logic [15:0] a2, input logic [31:0] w2);
    test_write(a1, d1, 1);
    test_read(a2, w2, int'($urandom_range(1, 6)), 3);
  endtask

  initial begin
    test_reset();
    test_write(16'h0042, 32'hDEADBEEF, 3);
    test_read(16'h0010, 32'h12345678, 3, 3);
    test_read(16'h0020, 32'h0BAD_F00D, 0, 3);
    test_read(16'h0030, 32'h5555_AAAA, 20, 3);
    test_read(16'h0040, 32'hCAFE_1234, int'(TMO), 3);
    test_read(16'h0050, 32'h7777_8888, int'(TMO) + 1, 3);
    test_read(16'h0060, 32'h0102_0304, 1, 3);
    test_write_abort(16'h0077, 32'hA5A5_5A5A);
    test_reset_mid_read(16'h0088, 32'h9ABC_DEF0);
    for (int i = 0; i < 5; i++)
      test_write(16'($urandom), 32'($urandom), int'($urandom_range(1, 4)));
    for (int i = 0; i < 5; i++)
      test_read(16'($urandom), 32'($urandom), int'($urandom_range(1, 12)), 3);
    for (int i = 0; i < 2; i++)
      test_back_to_back(16'($urandom), 32'($urandom), 16'($urandom), 32'($urandom));
    n_checks++;
    if (drive_bad != 0) $display("FAIL da_turnaround: got %0d cycles driving with oe high expected 0", drive_bad);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
